ad9517_spi_master: RTL

SPI bus engine serving the AD9517 clock-chip configuration path. It accepts single-frame write and read commands on a cmd/busy handshake from the configuration sequencer and serialises each frame MSB-first onto the AD9517 serial port. On reads it releases SDIO after the instruction phase and captures the returned register byte. It sits between the configuration FSM and the top-level SDIO tri-state buffer.

---
 rtl/ad9517_spi_master.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ad9517_spi_master.sv
// AD9517 serial-port engine: one mode-0 frame per command, MSB first, with
// SDIO turnaround and read-byte capture on read frames.
//
// state | meaning
// IDLE  | waiting for wr/rd command, busy low
// SETUP | cs_n asserted, first bit on mosi, CS_SETUP cycles
// SHIFT | N bits, CLK_DIV cycles sclk low then CLK_DIV cycles sclk high each
// HOLD  | sclk low, cs_n still asserted, CS_HOLD cycles
// GAP   | cs_n released, busy still high, CS_IDLE cycles
module ad9517_spi_master #(
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int CLK_DIV         = 4,
  parameter int CS_SETUP        = 2,
  parameter int CS_HOLD         = 2,
  parameter int CS_IDLE         = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_spi_wr_cmd,
  input  logic                       i_spi_rd_cmd,
  input  logic [MOSI_DATA_WIDTH-1:0] i_spi_wr_data,
  output logic [MISO_DATA_WIDTH-1:0] o_spi_rd_data,
  output logic                       o_spi_rd_valid,
  output logic                       o_spi_busy,
  output logic                       o_spi_cs_n,
  output logic                       o_spi_sclk,
  output logic                       o_spi_mosi,
  output logic                       o_spi_sdio_oe,
  input  logic                       i_spi_miso
);

  localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ?
                           ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE) :
                           ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
  localparam int TMR_W  = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = 5;

  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(MOSI_DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  RX_FIRST   = BIT_W'(MOSI_DATA_WIDTH - MISO_DATA_WIDTH);
  localparam logic [HALF_W-1:0] HALF_LOAD  = HALF_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0]  SETUP_LOAD = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0]  HOLD_LOAD  = TMR_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0]  IDLE_LOAD  = TMR_W'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                     r_state;
  logic [TMR_W-1:0]           r_tmr;
  logic [HALF_W-1:0]          r_half;
  logic [BIT_W-1:0]           r_bit;
  logic [MOSI_DATA_WIDTH-1:0] r_shift;
  logic [MISO_DATA_WIDTH-1:0] r_cap;
  logic                       r_rd;
  logic                       r_cs_n;
  logic                       r_sclk;
  logic                       r_mosi;
  logic                       r_oe;
  logic                       r_busy;
  logic [MISO_DATA_WIDTH-1:0] r_rd_data;
  logic                       r_rd_valid;

  state_t                     w_state_nxt;
  logic [TMR_W-1:0]           w_tmr_nxt;
  logic [HALF_W-1:0]          w_half_nxt;
  logic [BIT_W-1:0]           w_bit_nxt;
  logic [MOSI_DATA_WIDTH-1:0] w_shift_nxt;
  logic [MISO_DATA_WIDTH-1:0] w_cap_nxt;
  logic                       w_rd_nxt;
  logic                       w_cs_n_nxt;
  logic                       w_sclk_nxt;
  logic                       w_mosi_nxt;
  logic                       w_oe_nxt;
  logic                       w_busy_nxt;
  logic [MISO_DATA_WIDTH-1:0] w_rd_data_nxt;
  logic                       w_rd_valid_nxt;

  logic [MOSI_DATA_WIDTH-1:0] w_shift_sh;
  logic [BIT_W-1:0]           w_bit_inc;
  logic                       w_rx_bit;

  assign w_shift_sh = r_shift << 1;
  assign w_bit_inc  = r_bit + BIT_W'(1);
  // next bit belongs to the read-data phase: SDIO is handed to the AD9517
  assign w_rx_bit   = r_rd && (w_bit_inc >= RX_FIRST);

  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_nxt      = r_tmr;
    w_half_nxt     = r_half;
    w_bit_nxt      = r_bit;
    w_shift_nxt    = r_shift;
    w_cap_nxt      = r_cap;
    w_rd_nxt       = r_rd;
    w_cs_n_nxt     = r_cs_n;
    w_sclk_nxt     = r_sclk;
    w_mosi_nxt     = r_mosi;
    w_oe_nxt       = r_oe;
    w_busy_nxt     = r_busy;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_spi_wr_cmd || i_spi_rd_cmd) begin
          w_state_nxt = S_SETUP;
          w_tmr_nxt   = SETUP_LOAD;
          w_shift_nxt = i_spi_wr_data;
          w_cap_nxt   = '0;
          w_rd_nxt    = i_spi_rd_cmd;
          w_cs_n_nxt  = 1'b0;
          w_sclk_nxt  = 1'b0;
          w_mosi_nxt  = i_spi_wr_data[MOSI_DATA_WIDTH-1];
          w_oe_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
          // clear so an ID check cannot match a byte from an earlier read
          if (i_spi_rd_cmd) begin
            w_rd_data_nxt = '0;
          end
        end
      end

      S_SETUP: begin
        if (r_tmr == '0) begin
          w_state_nxt = S_SHIFT;
          w_half_nxt  = HALF_LOAD;
          w_bit_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end

      S_SHIFT: begin
        if (r_rd && r_sclk && (r_half == HALF_LOAD) && (r_bit >= RX_FIRST)) begin
          w_cap_nxt = MISO_DATA_WIDTH'({r_cap, i_spi_miso});
        end
        if (r_half != '0) begin
          w_half_nxt = r_half - HALF_W'(1);
        end else if (!r_sclk) begin
          w_sclk_nxt = 1'b1;
          w_half_nxt = HALF_LOAD;
        end else if (r_bit == LAST_BIT) begin
          w_state_nxt = S_HOLD;
          w_tmr_nxt   = HOLD_LOAD;
          w_sclk_nxt  = 1'b0;
        end else begin
          w_bit_nxt   = w_bit_inc;
          w_sclk_nxt  = 1'b0;
          w_half_nxt  = HALF_LOAD;
          w_shift_nxt = w_shift_sh;
          if (w_rx_bit) begin
            w_oe_nxt   = 1'b0;
            w_mosi_nxt = 1'b0;
          end else begin
            w_mosi_nxt = w_shift_sh[MOSI_DATA_WIDTH-1];
          end
        end
      end

      S_HOLD: begin
        if (r_tmr == '0) begin
          w_state_nxt = S_GAP;
          w_tmr_nxt   = IDLE_LOAD;
          w_cs_n_nxt  = 1'b1;
          w_oe_nxt    = 1'b0;
          w_mosi_nxt  = 1'b0;
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end

      S_GAP: begin
        if (r_tmr == '0) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          if (r_rd) begin
            w_rd_data_nxt  = r_cap;
            w_rd_valid_nxt = 1'b1;
          end
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tmr      <= '0;
      r_half     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_cap      <= '0;
      r_rd       <= 1'b0;
      r_cs_n     <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_half     <= w_half_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_cap      <= w_cap_nxt;
      r_rd       <= w_rd_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_sclk     <= w_sclk_nxt;
      r_mosi     <= w_mosi_nxt;
      r_oe       <= w_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
    end
  end

  assign o_spi_rd_data  = r_rd_data;
  assign o_spi_rd_valid = r_rd_valid;
  assign o_spi_busy     = r_busy;
  assign o_spi_cs_n     = r_cs_n;
  assign o_spi_sclk     = r_sclk;
  assign o_spi_mosi     = r_mosi;
  assign o_spi_sdio_oe  = r_oe;

endmodule
